div_seq: RTL and testbench

//  Multi-cycle radix-2 restoring divider with its own sequencing FSM for DIV/DIVU.

---
 rtl/div_if.sv | 12 +
 rtl/div_seq.sv | 71 +++++++
 tb/tb_div_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// div_if: request/result bundle between the execute stage and the sequential divider.
interface div_if #(parameter int WIDTH = 32);
  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               start;
  logic               annul;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  modport master (output signed_div, opdata1, opdata2, start, annul, input result, ready);
  modport slave  (input signed_div, opdata1, opdata2, start, annul, output result, ready);
endinterface

// File: rtl/div_seq.sv
// div_seq: radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// result = {remainder, quotient}; divide-by-zero short-circuits to a zero result.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic  clk,
  input logic  rst_n,
  div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;
  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   dvd, divisor, q_fix, r_fix;
  logic [WIDTH:0]     shifted, trial;
  logic               s1, s2, sg, ready;
  logic [2*WIDTH-1:0] result;
  logic               last;
  assign bus.result = result;
  assign bus.ready  = ready;
  assign last = cnt == CNT_W'(WIDTH);
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = bus.start && !bus.annul ? (bus.opdata2 == '0 ? BYZERO : ON) : IDLE;
      BYZERO:  state_n = END;
      ON:      state_n = bus.annul ? IDLE : (last ? END : ON);
      END:     state_n = bus.start ? END : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // dvd doubles as the quotient: dividend bits shift out the top as quotient bits enter the bottom
  always_comb begin
    shifted = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    q_fix   = sg && (s1 ^ s2) ? -dvd : dvd;
    r_fix   = sg && s1 ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      dvd     <= '0;
      divisor <= '0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      sg      <= 1'b0;
      ready   <= 1'b0;
      result  <= '0;
    end else begin
      state <= state_n;
      ready <= state_n == END;
      if (state == IDLE && state_n == ON) begin
        cnt     <= '0;
        rem     <= '0;
        s1      <= bus.opdata1[WIDTH-1];
        s2      <= bus.opdata2[WIDTH-1];
        sg      <= bus.signed_div;
        dvd     <= bus.signed_div && bus.opdata1[WIDTH-1] ? -bus.opdata1 : bus.opdata1;
        divisor <= bus.signed_div && bus.opdata2[WIDTH-1] ? -bus.opdata2 : bus.opdata2;
      end else if (state == ON && !last) begin
        rem <= trial[WIDTH] ? shifted : trial;
        dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
        cnt <= cnt + 1'b1;
      end
      result <= state_n == IDLE ? '0 : (state == ON && state_n == END) ? {r_fix, q_fix} : result;
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and random divides checked against a scoreboard of expected results.
module tb_div_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  logic [63:0] sb[$];
  div_if #(.WIDTH(32)) bus ();
  div_seq #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    if (b == 0) return 64'd0;
    ma = sd && a[31] ? -a : a;
    mb = sd && b[31] ? -b : b;
    q = ma / mb;
    r = ma % mb;
    if (sd && (a[31] ^ b[31])) q = -q;
    if (sd && a[31]) r = -r;
    return {r, q};
  endfunction
  // Operands are scrambled after the accepting edge to prove they were latched.
  task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input int hold);
    int n;
    logic [63:0] e;
    sb.push_back(exp);
    bus.signed_div = sd;
    bus.opdata1 = a;
    bus.opdata2 = b;
    bus.start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.opdata1 = $urandom;
      bus.opdata2 = $urandom;
      bus.signed_div = 1'($urandom_range(0, 1));
    end while (!bus.ready && n < 100);
    check("latency", 64'(n - 1), 64'(lat));
    e = sb.pop_front();
    check("result", bus.result, e);
    repeat (hold) begin
      @(negedge clk);
      check("hold_ready", 64'(bus.ready), 64'd1);
      check("hold_result", bus.result, e);
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("ready_drop", 64'(bus.ready), 64'd0);
    check("result_clear", bus.result, 64'd0);
  endtask
  initial begin
    logic rose;
    int n;
    logic [31:0] a, b;
    logic sd;
    bus.signed_div = 1'b0;
    bus.opdata1 = '0;
    bus.opdata2 = '0;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_result", bus.result, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 5);
    do_div(1'b1, -32'sd7, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0);
    do_div(1'b1, 32'd7, -32'sd2, {32'd1, 32'hFFFFFFFD}, 33, 0);
    do_div(1'b1, 32'd5, 32'd0, 64'd0, 1, 0);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33, 0);
    do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0}, 33, 0);
    // annul in the middle of a divide
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'hFFFFFFFF;
    bus.opdata2 = 32'd3;
    bus.start = 1'b1;
    repeat (11) @(negedge clk);
    bus.annul = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.annul = 1'b0;
    rose = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready) rose = 1'b1;
    end
    check("annul_no_ready", 64'(rose), 64'd0);
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);
    // annul with start in IDLE is not accepted
    bus.opdata1 = 32'd9;
    bus.opdata2 = 32'd0;
    bus.start = 1'b1;
    bus.annul = 1'b1;
    repeat (3) @(negedge clk);
    check("annul_idle", 64'(bus.ready), 64'd0);
    bus.start = 1'b0;
    bus.annul = 1'b0;
    @(negedge clk);
    // async reset mid-divide, then mid-END
    bus.opdata1 = 32'd1000;
    bus.opdata2 = 32'd3;
    bus.start = 1'b1;
    repeat (21) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_on_ready", 64'(bus.ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.opdata1 = 32'd1000;
    bus.opdata2 = 32'd3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ready && n < 100);
    check("fresh_latency", 64'(n - 1), 64'd33);
    check("fresh_result", bus.result, {32'd1, 32'd333});
    #2 rst_n = 1'b0;
    #1 check("rst_end_ready", 64'(bus.ready), 64'd0);
    check("rst_end_result", bus.result, 64'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i == 7) b = 32'd0;
      sd = 1'($urandom_range(0, 1));
      do_div(sd, a, b, model(sd, a, b), b == 0 ? 1 : 33, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
